regfile_mp: RTL and testbench

- Parametrised multi-port register file; next generation of the single-cycle core's 2R/1W integer file.
- Serves both the integer datapath and the FPU register bank.
- Adds configurable width/depth/read-port count, two write ports with fixed priority, write-to-read bypass, optional hardwired zero register.
- Adds a hardware clear sequencer, replacing file-based initialisation on reset.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clr_seq.sv | 51 +++++
 rtl/regfile_mp.sv | 105 ++++++++++
 tb/tb_regfile_mp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register files (integer and FPU banks).
package regfile_pkg;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

  function automatic int rf_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every entry after reset, then releases the file to traffic.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter  int DEPTH = RF_DEPTH,
  localparam int AW    = rf_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rf_state_t     state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;

  // NOTE: state is updated with non-blocking assignments; reset is asynchronous so ready drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RF_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_we      = 1'b0;
    ready       = 1'b0;
    case (state)
      RF_INIT: begin
        clr_we      = 1'b1;
        clr_cnt_nxt = clr_cnt + AW'(1);
        if (clr_cnt == AW'(DEPTH - 1)) begin
          state_nxt   = RF_RUN;
          clr_cnt_nxt = '0;
        end
      end
      RF_RUN:  ready = 1'b1;
      default: state_nxt = RF_INIT;
    endcase
  end

  assign clr_addr = clr_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised writes, bypass, zero register.
// Define REGFILE_SCOREBOARD_EN to add per-register pending bits (iss_v/iss_a in, pend out).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int               WIDTH      = RF_WIDTH,
  parameter  int               DEPTH      = RF_DEPTH,
  parameter  int               NUM_RD     = 2,
  parameter  int               ZERO_REG   = 1,
  parameter  int               BYPASS     = 1,
  parameter  logic [WIDTH-1:0] INIT_VALUE = '0,
  localparam int               AW         = rf_aw(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*AW-1:0]    ra,
  output logic [NUM_RD*WIDTH-1:0] rd,
  input  logic                    we0,
  input  logic [AW-1:0]           wa0,
  input  logic [WIDTH-1:0]        wd0,
  input  logic                    we1,
  input  logic [AW-1:0]           wa1,
  input  logic [WIDTH-1:0]        wd1,
  output logic                    ready
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                    iss_v,
  input  logic [AW-1:0]           iss_a,
  output logic [NUM_RD-1:0]       pend
`endif
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr0_ok, wr1_ok;

  regfile_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writes are only accepted in RUN; the zero register silently drops them.
  assign wr0_ok = ready && we0 && !(ZERO_REG != 0 && wa0 == '0);
  assign wr1_ok = ready && we1 && !(ZERO_REG != 0 && wa1 == '0);

  // NOTE: the storage array has no reset; the clear sequencer initialises it after rst.
  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      if (clr_we && clr_addr == AW'(j))
        mem[j] <= INIT_VALUE;
      else if (wr0_ok && wa0 == AW'(j))
        mem[j] <= wd0;
      else if (wr1_ok && wa1 == AW'(j))
        mem[j] <= wd1;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else if (!ready) begin
      pend_q <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if (iss_v && iss_a == AW'(j) && !(ZERO_REG != 0 && j == 0))
          pend_q[j] <= 1'b1;
        else if ((we0 && wa0 == AW'(j)) || (we1 && wa1 == AW'(j)))
          pend_q[j] <= 1'b0;
      end
    end
  end
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] word;

    assign addr = ra[i*AW +: AW];

    // Zero register and INIT masking are applied last so they override any bypass.
    always_comb begin
      word = mem[addr];
      if (BYPASS != 0 && wr0_ok && wa0 == addr)
        word = wd0;
      else if (BYPASS != 0 && wr1_ok && wa1 == addr)
        word = wd1;
      if (!ready || (ZERO_REG != 0 && addr == '0))
        word = '0;
    end

    assign rd[i*WIDTH +: WIDTH] = word;

`ifdef REGFILE_SCOREBOARD_EN
    assign pend[i] = ready && pend_q[addr];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (integer-style and FPU-style) against an array model plus literals.
module tb_regfile_mp;

  localparam int          W      = 32;
  localparam int          D      = 32;
  localparam int          NR     = 2;
  localparam int          AW     = 5;
  localparam logic [31:0] INIT_B = 32'h5A5A_0F0F;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR*AW-1:0] ra;
  logic          we0, we1;
  logic [AW-1:0] wa0, wa1;
  logic [W-1:0]  wd0, wd1;
  logic [NR*W-1:0] rd_a, rd_b;
  logic          ready_a, ready_b;
`ifdef REGFILE_SCOREBOARD_EN
  logic          iss_v;
  logic [AW-1:0] iss_a;
  logic [NR-1:0] pend_a, pend_b;
`endif

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1), .INIT_VALUE('0)) u_dut_a (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ready(ready_a)
`ifdef REGFILE_SCOREBOARD_EN
    , .iss_v(iss_v), .iss_a(iss_a), .pend(pend_a)
`endif
  );

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0), .INIT_VALUE(INIT_B)) u_dut_b (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ready(ready_b)
`ifdef REGFILE_SCOREBOARD_EN
    , .iss_v(iss_v), .iss_a(iss_a), .pend(pend_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: cycles since reset release decide readiness; arrays hold the architectural contents.
  int          cnt_m = 0;
  logic [W-1:0] mem_a [D];
  logic [W-1:0] mem_b [D];
  bit          pend_ma [D];
  bit          pend_mb [D];

  always @(posedge clk or posedge rst) begin
    if (rst)          cnt_m <= 0;
    else if (cnt_m < D) cnt_m <= cnt_m + 1;
  end

  always @(posedge clk) begin
    if (!rst && cnt_m < D) begin
      mem_a[cnt_m] <= '0;
      mem_b[cnt_m] <= INIT_B;
      for (int k = 0; k < D; k++) begin
        pend_ma[k] <= 1'b0;
        pend_mb[k] <= 1'b0;
      end
    end else if (!rst) begin
      if (we1 && wa1 != 0) mem_a[wa1] <= wd1;
      if (we0 && wa0 != 0) mem_a[wa0] <= wd0;
      if (we1) mem_b[wa1] <= wd1;
      if (we0) mem_b[wa0] <= wd0;
`ifdef REGFILE_SCOREBOARD_EN
      if (we1) begin pend_ma[wa1] <= 1'b0; pend_mb[wa1] <= 1'b0; end
      if (we0) begin pend_ma[wa0] <= 1'b0; pend_mb[wa0] <= 1'b0; end
      if (iss_v && iss_a != 0) pend_ma[iss_a] <= 1'b1;
      if (iss_v) pend_mb[iss_a] <= 1'b1;
`endif
    end
  end

  function automatic logic model_ready();
    return !rst && cnt_m >= D;
  endfunction

  function automatic logic [W-1:0] exp_rd(input bit zero, input bit byp, input logic [AW-1:0] a,
                                          input logic [W-1:0] stored);
    if (!model_ready())            return '0;
    if (zero && a == 0)            return '0;
    if (byp && we0 && wa0 == a)    return wd0;
    if (byp && we1 && wa1 == a)    return wd1;
    return stored;
  endfunction

  // Per-cycle comparison, sampled 2 time units after the falling edge.
  always @(negedge clk) begin
    logic [AW-1:0] a;
    #2;
    check("ready_a", ready_a, model_ready());
    check("ready_b", ready_b, model_ready());
    for (int i = 0; i < NR; i++) begin
      a = ra[i*AW +: AW];
      check($sformatf("rd_a[%0d] ra=%0d", i, a), rd_a[i*W +: W], exp_rd(1'b1, 1'b1, a, mem_a[a]));
      check($sformatf("rd_b[%0d] ra=%0d", i, a), rd_b[i*W +: W], exp_rd(1'b0, 1'b0, a, mem_b[a]));
`ifdef REGFILE_SCOREBOARD_EN
      check($sformatf("pend_a[%0d]", i), pend_a[i], model_ready() && pend_ma[a]);
      check($sformatf("pend_b[%0d]", i), pend_b[i], model_ready() && pend_mb[a]);
`endif
    end
  end

  task automatic apply(input logic w0, input int a0, input logic [W-1:0] d0,
                       input logic w1, input int a1, input logic [W-1:0] d1,
                       input int r0, input int r1);
    @(negedge clk);
    we0 = w0; wa0 = AW'(a0); wd0 = d0;
    we1 = w1; wa1 = AW'(a1); wd1 = d1;
    ra  = {AW'(r1), AW'(r0)};
`ifdef REGFILE_SCOREBOARD_EN
    iss_v = 1'b0;
`endif
    #3;
  endtask

  // Counts posedges from reset release to ready; optionally pokes writes that must be dropped.
  task automatic wait_ready(input string name, input int poke_at);
    int c;
    c = 0;
    while (!ready_a && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      if (c == poke_at) begin
        we0 = 1'b1; wa0 = AW'(2); wd0 = 32'hCAFE_0002;
        we1 = 1'b1; wa1 = AW'(3); wd1 = 32'hCAFE_0003;
      end else if (c == poke_at + 1) begin
        we0 = 1'b0; we1 = 1'b0;
      end
    end
    check(name, 64'(c), 64'd32);
  endtask

  function automatic logic [W-1:0] port(input logic [NR*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    ra  = {AW'(6), AW'(5)};
`ifdef REGFILE_SCOREBOARD_EN
    iss_v = 1'b0; iss_a = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("ready_in_reset", ready_a, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    wait_ready("ready_latency", 20);

    apply(0, 0, 0, 0, 0, 0, 2, 3);
    check("init_drop_a2", port(rd_a, 0), 32'h0);
    check("init_drop_b3", port(rd_b, 1), INIT_B);

    apply(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5, 0);
    check("bypass_a", port(rd_a, 0), 32'hDEAD_BEEF);
    check("nobypass_b_old", port(rd_b, 0), INIT_B);
    apply(0, 0, 0, 0, 0, 0, 5, 0);
    check("nobypass_b_new", port(rd_b, 0), 32'hDEAD_BEEF);

    apply(1, 7, 32'h11, 1, 7, 32'h22, 7, 7);
    check("collide_bypass_a", port(rd_a, 1), 32'h11);
    apply(0, 0, 0, 0, 0, 0, 7, 7);
    check("collide_a", port(rd_a, 0), 32'h11);
    check("collide_b", port(rd_b, 1), 32'h11);

    apply(1, 3, 32'hA, 1, 4, 32'hB, 3, 4);
    check("dual_bypass_a0", port(rd_a, 0), 32'hA);
    check("dual_bypass_a1", port(rd_a, 1), 32'hB);
    apply(0, 0, 0, 0, 0, 0, 3, 4);
    check("dual_b0", port(rd_b, 0), 32'hA);
    check("dual_b1", port(rd_b, 1), 32'hB);

    apply(0, 0, 0, 1, 9, 32'h1234, 0, 9);
    check("bypass_port1_a", port(rd_a, 1), 32'h1234);

    apply(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    check("zero_bypass_a", port(rd_a, 0), 32'h0);
    check("zero_old_b", port(rd_b, 0), INIT_B);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check("zero_a", port(rd_a, 0), 32'h0);
    check("zero_off_b", port(rd_b, 0), 32'hFFFF_FFFF);

`ifdef REGFILE_SCOREBOARD_EN
    apply(0, 0, 0, 0, 0, 0, 9, 0);
    iss_v = 1'b1; iss_a = AW'(9);
    apply(0, 0, 0, 1, 9, 32'h99, 9, 0);
    check("pend_set", pend_a[0], 1'b1);
    iss_v = 1'b1; iss_a = AW'(9);
    apply(0, 0, 0, 0, 0, 0, 9, 0);
    check("pend_set_wins", pend_a[0], 1'b1);
    apply(1, 9, 32'h98, 0, 0, 0, 9, 0);
    apply(0, 0, 0, 0, 0, 0, 9, 0);
    check("pend_cleared", pend_a[0], 1'b0);
    apply(0, 0, 0, 0, 0, 0, 0, 9);
    iss_v = 1'b1; iss_a = AW'(0);
    apply(0, 0, 0, 0, 0, 0, 0, 9);
    check("pend_zero_a", pend_a[0], 1'b0);
    check("pend_zero_b", pend_b[0], 1'b1);
`endif

    // Mixed traffic, including bypass hits and writes to the zero register.
    for (int k = 0; k < 48; k++) begin
      apply((k % 3) != 0, (k * 7) % 32, W'(32'h1000_0000 + k * 32'h0101),
            (k % 2) == 0, (k * 5 + 3) % 32, W'(32'hA000_0000 ^ k),
            (k * 3) % 32, (k * 7) % 32);
    end

    // Reset mid-INIT must restart the clear from entry 0.
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0;
    rst = 1'b1;
    #3;
    check("rst_async_run", ready_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_init", ready_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("ready_latency_restart", -5);

    apply(1, 5, 32'h5555_0005, 1, 6, 32'h6666_0006, 5, 6);
    apply(1, 8, 32'h8888_0008, 1, 10, 32'hAAAA_000A, 8, 10);
    apply(0, 0, 0, 0, 0, 0, 5, 6);
    check("pre_rst_b5", port(rd_b, 0), 32'h5555_0005);

    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_drop", ready_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("ready_latency_reclear", -5);
    apply(0, 0, 0, 0, 0, 0, 5, 6);
    check("reclear_a5", port(rd_a, 0), 32'h0);
    check("reclear_b6", port(rd_b, 1), INIT_B);

    apply(0, 0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
